// File: rtl/sort_xcel_pkg.sv
// Shared types and the slot ordering function for the streaming insertion sorter.
// Build with SORT_XCEL_SIGNED_CMP_EN defined to order words as two's-complement signed.
package sort_xcel_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_X    = 2'd1,
        SEL_NBR  = 2'd2
    } slot_sel_t;

    localparam int CMP_W = 64;

`ifdef SORT_XCEL_SIGNED_CMP_EN
    localparam bit SIGNED_CMP = 1'b1;
`else
    localparam bit SIGNED_CMP = 1'b0;
`endif

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
    function automatic logic word_lt(input logic [CMP_W-1:0] a,
                                     input logic [CMP_W-1:0] b,
                                     input int               nbits);
        logic [CMP_W-1:0] bias;
        bias = SIGNED_CMP ? (CMP_W'(1) << (nbits - 1)) : '0;
        return (a ^ bias) < (b ^ bias);
    endfunction

endpackage

// File: rtl/sort_xcel_insert_slot.sv
// One sorter slot: value register, occupied bit, strict less-than compare and next-value mux.
module sort_xcel_insert_slot
    import sort_xcel_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nbits-1:0] x,
    input  slot_sel_t          sel,
    input  logic [p_nbits-1:0] nbr_v,
    input  logic               nbr_occ,
    output logic [p_nbits-1:0] v,
    output logic               occ,
    output logic               lt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            v   <= '0;
            occ <= 1'b0;
        end else begin
            case (sel)
                SEL_X: begin
                    v   <= x;
                    occ <= 1'b1;
                end
                SEL_NBR: begin
                    v   <= nbr_v;
                    occ <= nbr_occ;
                end
                default: begin
                    v   <= v;
                    occ <= occ;
                end
            endcase
        end
    end

    // Strict compare keeps equal words in arrival order.
    assign lt = !occ || word_lt(CMP_W'(x), CMP_W'(v), p_nbits);

endmodule

// File: rtl/sort_xcel_insert_array.sv
// Streaming insertion sorter: loads a frame one word per cycle, then drains it smallest first.
// Optional signed ordering via SORT_XCEL_SIGNED_CMP_EN; ready/valid are pure functions of state.
module sort_xcel_insert_array
    import sort_xcel_pkg::*;
#(
    parameter int p_nbits  = 32,
    parameter int p_ncells = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [p_nbits-1:0]            in_msg,
    input  logic                          in_last,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [p_nbits-1:0]            out_msg,
    output logic                          out_last,
    output logic [$clog2(p_ncells+1)-1:0] count
);

    localparam int CW = $clog2(p_ncells + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(p_ncells - 1);

    state_t              state;
    state_t              state_next;
    logic [p_nbits-1:0]  v       [p_ncells];
    logic                occ     [p_ncells];
    logic [p_nbits-1:0]  nbr_v   [p_ncells];
    logic                nbr_occ [p_ncells];
    slot_sel_t           sel     [p_ncells];
    logic [p_ncells-1:0] lt;
    logic                in_fire;
    logic                out_fire;
    logic                below;

    assign in_rdy   = (state == ST_LOAD);
    assign out_val  = (state == ST_DRAIN);
    assign in_fire  = in_val && in_rdy;
    assign out_fire = out_val && out_rdy;
    assign out_msg  = v[0];
    assign out_last = out_val && (count == CW'(1));

    for (genvar i = 0; i < p_ncells; i++) begin : g_slot
        // Neighbour is the slot above while draining, the slot below while loading.
        if (i == 0) begin : g_bot
            assign nbr_v[i]   = (state == ST_DRAIN) ? v[i+1]   : '0;
            assign nbr_occ[i] = (state == ST_DRAIN) ? occ[i+1] : 1'b0;
        end else if (i == p_ncells - 1) begin : g_top
            assign nbr_v[i]   = (state == ST_DRAIN) ? '0   : v[i-1];
            assign nbr_occ[i] = (state == ST_DRAIN) ? 1'b0 : occ[i-1];
        end else begin : g_mid
            assign nbr_v[i]   = (state == ST_DRAIN) ? v[i+1]   : v[i-1];
            assign nbr_occ[i] = (state == ST_DRAIN) ? occ[i+1] : occ[i-1];
        end

        sort_xcel_insert_slot #(
            .p_nbits (p_nbits)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .x       (in_msg),
            .sel     (sel[i]),
            .nbr_v   (nbr_v[i]),
            .nbr_occ (nbr_occ[i]),
            .v       (v[i]),
            .occ     (occ[i]),
            .lt      (lt[i])
        );
    end

    // Insert position is the lowest slot with lt set; everything above it shifts up.
    always_comb begin
        below = 1'b0;
        for (int i = 0; i < p_ncells; i++) begin
            sel[i] = SEL_HOLD;
            if (out_fire) begin
                sel[i] = SEL_NBR;
            end else if (in_fire) begin
                if (below) begin
                    sel[i] = SEL_NBR;
                end else if (lt[i]) begin
                    sel[i] = SEL_X;
                end
            end
            below = below | lt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (in_fire && (in_last || count == FULL_M1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && count == CW'(1)) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (in_fire) begin
            count <= count + CW'(1);
        end else if (out_fire) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_sort_xcel_insert_array.sv
// Directed self-checking bench for the insertion sorter with hand-computed expected orderings.
module tb_sort_xcel_insert_array;

    localparam int NB = 32;
    localparam int NC = 8;
    localparam int CW = $clog2(NC + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [NB-1:0] in_msg = '0;
    logic          in_last = 1'b0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] out_msg;
    logic          out_last;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sort_xcel_insert_array #(
        .p_nbits  (NB),
        .p_ncells (NC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .in_last  (in_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; leaves the bench at the same phase.
    task automatic push(input logic [NB-1:0] w, input logic last);
        chk("push_in_rdy", 64'(in_rdy), 64'd1);
        in_val  = 1'b1;
        in_msg  = w;
        in_last = last;
        @(posedge clk);
        #1;
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pull(input logic [NB-1:0] w, input logic last);
        int budget;
        budget = 0;
        out_rdy = 1'b1;
        while (!out_val && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("pull_out_val", 64'(out_val), 64'd1);
        chk("pull_in_rdy", 64'(in_rdy), 64'd0);
        chk("pull_out_msg", 64'(out_msg), 64'(w));
        chk("pull_out_last", 64'(out_last), 64'(last));
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
        chk({tag, "_out_val"}, 64'(out_val), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check_idle("rst");
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);

        // Basic frame {5,3,9,1}
        push(5, 0); push(3, 0); push(9, 0); push(1, 1);
        chk("f1_turnaround", 64'(out_val), 64'd1);
        chk("f1_count", 64'(count), 64'd4);
        pull(1, 0); pull(3, 0); pull(5, 0); pull(9, 1);
        check_idle("f1_done");

        // Duplicates stay grouped
        push(7, 0); push(2, 0); push(7, 0); push(2, 1);
        pull(2, 0); pull(2, 0); pull(7, 0); pull(7, 1);
        check_idle("dup_done");

        // Full frame forces drain without in_last
        for (int k = 8; k >= 1; k--) push(NB'(k), 0);
        chk("full_forced", 64'(out_val), 64'd1);
        chk("full_count", 64'(count), 64'd8);
        for (int k = 1; k <= 8; k++) pull(NB'(k), k == 8);
        check_idle("full_done");

        // Late in_last opens a one-word frame
        push(42, 1);
        pull(42, 1);
        check_idle("stray_done");

        // Backpressure holds output stable
        push(4, 0); push(1, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("bp_msg1", 64'(out_msg), 64'd1);
            chk("bp_last1", 64'(out_last), 64'd0);
            chk("bp_count2", 64'(count), 64'd2);
        end
        pull(1, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("bp_msg4", 64'(out_msg), 64'd4);
            chk("bp_last4", 64'(out_last), 64'd1);
        end
        pull(4, 1);
        check_idle("bp_done");

        // Reset mid-frame discards partial contents
        push(6, 0); push(2, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("mid_rst");
        push(3, 1);
        pull(3, 1);
        check_idle("mid_rst_done");

        // Sign-sensitive ordering
        push(32'h0000_0001, 0); push(32'hFFFF_FFFF, 0); push(32'h8000_0000, 1);
`ifdef SORT_XCEL_SIGNED_CMP_EN
        pull(32'h8000_0000, 0); pull(32'hFFFF_FFFF, 0); pull(32'h0000_0001, 1);
`else
        pull(32'h0000_0001, 0); pull(32'h8000_0000, 0); pull(32'hFFFF_FFFF, 1);
`endif
        check_idle("sign_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
